phalanx_mixer: RTL and testbench

Parametrised output mixer for the multi-element pulse generator. It takes per-element I/Q sample streams (tslice samples per clock) and a per-element qubit-routing mask, and sums the routed elements into each qubit output. It then applies a programmable signed per-output gain, rounds, saturates, and presents DAC-ready words. It replaces the fixed-gain summing stage and adds gain control, clip detection, clip counters and a valid-tracked fixed-latency pipeline.

---
 rtl/phalanx_pkg.sv | 51 +++++
 rtl/phalanx_mixer_lane.sv | 53 +++++
 rtl/phalanx_mixer.sv | 118 +++++++++++
 tb/tb_phalanx_mixer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phalanx_pkg.sv
`default_nettype none
// ==========================================================================
// phalanx_pkg: shared gain, latency, rounding/saturation and index helpers.
// Revision: 1.0
// ==========================================================================
package phalanx_pkg;

    function automatic int UNITY_GAIN(input int gw);
        return 1 << (gw - 2);
    endfunction

    function automatic int MIX_LATENCY(input int nel);
        return $clog2(nel) + 3;
    endfunction

    function automatic int SEL_WIDTH(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round half toward +inf, then drop the gain fraction bits.
    function automatic longint round_shift(input longint v, input int gw);
        return (v + (64'sd1 <<< (gw - 3))) >>> (gw - 2);
    endfunction

    function automatic logic sat_clip(input longint v, input int dw);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic longint saturate(input longint v, input int dw);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    function automatic int dac_index(input int q, input int c, input int k, input int tslice);
        return (q * 2 + c) * tslice + k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phalanx_mixer_lane.sv
`default_nettype none
// ==========================================================================
// mix_lane: one (q,c,k) lane - mask, registered adder tree, gain, round/sat.
// Revision: 1.0
// ==========================================================================
module mix_lane
    import phalanx_pkg::*;
#(
    parameter int dw  = 16,
    parameter int nel = 8,
    parameter int gw  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [nel*dw-1:0]    samples,
    input  logic [nel-1:0]       mask,
    input  logic signed [gw-1:0] gain,
    output logic [dw-1:0]        word,
    output logic                 clip
);

    localparam int nell = $clog2(nel);
    localparam int npad = 1 << nell;
    localparam int sw   = dw + nell;
    localparam int pw   = sw + gw;

    // Heap-ordered tree: leaves at [npad, 2*npad), root at node[1].
    logic signed [sw-1:0] node [1:2*npad-1];
    logic signed [pw-1:0] prod;
    longint               rounded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 2 * npad; i++)
                node[i] <= '0;
            prod <= '0;
        end else begin
            for (int j = 0; j < nel; j++)
                node[npad+j] <= mask[j] ? sw'($signed(samples[j*dw +: dw])) : '0;
            for (int j = nel; j < npad; j++)
                node[npad+j] <= '0;
            for (int i = 1; i < npad; i++)
                node[i] <= node[2*i] + node[2*i+1];
            prod <= pw'(node[1]) * pw'(gain);
        end
    end

    assign rounded = round_shift(64'(prod), gw);
    assign word    = dw'(saturate(rounded, dw));
    assign clip    = sat_clip(rounded, dw);

endmodule
`default_nettype wire

// File: rtl/phalanx_mixer.sv
`default_nettype none
// ==========================================================================
// phalanx_mixer: routed I/Q summing mixer with per-output gain and clip stats.
// Revision: 1.0
// ==========================================================================
module phalanx_mixer
    import phalanx_pkg::*;
#(
    parameter int dw     = 16,
    parameter int nel    = 8,
    parameter int qbits  = 4,
    parameter int tslice = 4,
    parameter int gw     = 16,
    parameter int cw     = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [nel*tslice*dw-1:0]        xin,
    input  logic [nel*tslice*dw-1:0]        yin,
    input  logic [nel*qbits-1:0]            qsel,
    input  logic                            in_valid,
    input  logic                            daczero,
    input  logic [SEL_WIDTH(qbits)-1:0]     gaddr,
    input  logic [gw-1:0]                   gdata,
    input  logic                            gstrobe,
    input  logic                            clip_clear,
    output logic [qbits*2*tslice*dw-1:0]    dacout,
    output logic                            out_valid,
    output logic [qbits-1:0]                clip_sticky,
    output logic [qbits*cw-1:0]             clip_count
);

    localparam int lat = MIX_LATENCY(nel);

    logic [lat-1:0]               vpipe;
    logic signed [gw-1:0]         gain [qbits];
    logic [qbits*2*tslice*dw-1:0] lane_word;
    logic [qbits*2*tslice-1:0]    lane_clip;
    logic [qbits-1:0]             clip_event;

    // Lane words are laid out exactly like dacout, so the output load is a copy.
    for (genvar q = 0; q < qbits; q++) begin : g_q
        logic [nel-1:0] mask;
        for (genvar j = 0; j < nel; j++) begin : g_mask
            assign mask[j] = qsel[j*qbits+q];
        end

        assign clip_event[q] = vpipe[lat-2] & ~daczero & (|lane_clip[q*2*tslice +: 2*tslice]);

        for (genvar c = 0; c < 2; c++) begin : g_c
            for (genvar k = 0; k < tslice; k++) begin : g_k
                localparam int idx = dac_index(q, c, k, tslice);
                logic [nel*dw-1:0] samples;
                for (genvar j = 0; j < nel; j++) begin : g_samp
                    if (c == 0) begin : g_i
                        assign samples[j*dw +: dw] = xin[(j*tslice+k)*dw +: dw];
                    end else begin : g_qd
                        assign samples[j*dw +: dw] = yin[(j*tslice+k)*dw +: dw];
                    end
                end

                mix_lane #(
                    .dw  (dw),
                    .nel (nel),
                    .gw  (gw)
                ) u_lane (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .samples (samples),
                    .mask    (mask),
                    .gain    (gain[q]),
                    .word    (lane_word[idx*dw +: dw]),
                    .clip    (lane_clip[idx])
                );
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe  <= '0;
            dacout <= '0;
            for (int q = 0; q < qbits; q++)
                gain[q] <= gw'(UNITY_GAIN(gw));
        end else begin
            vpipe <= {vpipe[lat-2:0], in_valid};
            for (int q = 0; q < qbits; q++)
                if (gstrobe && (int'(gaddr) == q))
                    gain[q] <= gdata;
            if (daczero)
                dacout <= '0;
            else if (vpipe[lat-2])
                dacout <= lane_word;
        end
    end

    assign out_valid = vpipe[lat-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_sticky <= '0;
            clip_count  <= '0;
        end else begin
            for (int q = 0; q < qbits; q++) begin
                if (clip_clear) begin
                    clip_sticky[q]         <= 1'b0;
                    clip_count[q*cw +: cw] <= '0;
                end else if (clip_event[q]) begin
                    clip_sticky[q] <= 1'b1;
                    if (clip_count[q*cw +: cw] != '1)
                        clip_count[q*cw +: cw] <= clip_count[q*cw +: cw] + cw'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phalanx_mixer.sv
`default_nettype none
// ==========================================================================
// tb_phalanx_mixer: directed stimulus, cycle-history model, literal pins.
// Revision: 1.0
// ==========================================================================
module tb_phalanx_mixer;

    localparam int DW = 16, NEL = 8, QB = 4, TS = 4, GW = 16, CW = 4;
    localparam int NELL = 3, L = 6, MAXC = 1024;
    localparam int SW = 2 * TS * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [NEL*TS*DW-1:0]    xin, yin;
    logic [NEL*QB-1:0]       qsel;
    logic                    in_valid, daczero, gstrobe, clip_clear;
    logic [1:0]              gaddr;
    logic [GW-1:0]           gdata;
    logic [QB*SW-1:0]        dacout;
    logic                    out_valid;
    logic [QB-1:0]           clip_sticky;
    logic [QB*CW-1:0]        clip_count;

    phalanx_mixer #(
        .dw(DW), .nel(NEL), .qbits(QB), .tslice(TS), .gw(GW), .cw(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .xin(xin), .yin(yin), .qsel(qsel),
        .in_valid(in_valid), .daczero(daczero), .gaddr(gaddr), .gdata(gdata),
        .gstrobe(gstrobe), .clip_clear(clip_clear), .dacout(dacout),
        .out_valid(out_valid), .clip_sticky(clip_sticky), .clip_count(clip_count)
    );

    // Per-cycle input history and the expected output state derived from it.
    logic [NEL*TS*DW-1:0] hx [MAXC];
    logic [NEL*TS*DW-1:0] hy [MAXC];
    logic [NEL*QB-1:0]    hq [MAXC];
    bit                   hv [MAXC], hz [MAXC], hc [MAXC];
    longint               hg [MAXC][QB];
    int                   cyc = 0;
    logic [QB*SW-1:0]     exp_dac = '0;
    bit                   exp_v = 0;
    bit [QB-1:0]          exp_s = '0;
    int                   exp_cnt [QB] = '{default: 0};

    int compared = 0, mismatched = 0;

    function automatic int in_sample(input int n, input int c, input int j, input int k);
        logic signed [DW-1:0] s;
        s = c ? hy[n][(j*TS+k)*DW +: DW] : hx[n][(j*TS+k)*DW +: DW];
        return int'(s);
    endfunction

    function automatic int model_lane(input int n, input int q, input int c, input int k, output bit clip);
        longint sum, p, r;
        sum = 0;
        for (int j = 0; j < NEL; j++)
            if (hq[n][j*QB+q]) sum += in_sample(n, c, j, k);
        p = sum * hg[n+NELL][q];
        r = (p + 8192) >>> 14;
        clip = (r > 32767) || (r < -32768);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        int n, w;
        bit valid, mute, clr, cl, anyc;
        if (!rst_n) begin
            cyc = 0; exp_dac = '0; exp_v = 0; exp_s = '0;
            for (int q = 0; q < QB; q++) exp_cnt[q] = 0;
        end else if (cyc < MAXC - 1) begin
            hx[cyc] = xin; hy[cyc] = yin; hq[cyc] = qsel;
            hv[cyc] = in_valid; hz[cyc] = daczero; hc[cyc] = clip_clear;
            for (int q = 0; q < QB; q++)
                hg[cyc][q] = (gstrobe && gaddr == q) ? longint'($signed(gdata))
                           : (cyc == 0 ? 64'sd16384 : hg[cyc-1][q]);
            cyc++;
            n = cyc - L;
            valid = (n >= 0) && hv[n];
            mute = hz[cyc-1];
            clr = hc[cyc-1];
            exp_v = valid;
            for (int q = 0; q < QB; q++) begin
                anyc = 0;
                for (int c = 0; c < 2; c++)
                    for (int k = 0; k < TS; k++) begin
                        w = 0;
                        if (valid) begin
                            w = model_lane(n, q, c, k, cl);
                            anyc |= cl;
                        end
                        if (mute) exp_dac[((q*2+c)*TS+k)*DW +: DW] = '0;
                        else if (valid) exp_dac[((q*2+c)*TS+k)*DW +: DW] = DW'(w);
                    end
                if (clr) begin
                    exp_s[q] = 0; exp_cnt[q] = 0;
                end else if (valid && !mute && anyc) begin
                    exp_s[q] = 1;
                    if (exp_cnt[q] < (1 << CW) - 1) exp_cnt[q]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int q = 0; q < QB; q++) begin
            compared++;
            if (dacout[q*SW +: SW] !== exp_dac[q*SW +: SW]) begin
                mismatched++;
                $display("FAIL dacout_q%0d cyc %0d: got %h required %h", q, cyc, dacout[q*SW +: SW], exp_dac[q*SW +: SW]);
            end
            compared++;
            if (int'(clip_count[q*CW +: CW]) != exp_cnt[q]) begin
                mismatched++;
                $display("FAIL clip_count_q%0d cyc %0d: got %0d required %0d", q, cyc, clip_count[q*CW +: CW], exp_cnt[q]);
            end
        end
        compared++;
        if (out_valid !== exp_v) begin
            mismatched++;
            $display("FAIL out_valid cyc %0d: got %b required %b", cyc, out_valid, exp_v);
        end
        compared++;
        if (clip_sticky !== exp_s) begin
            mismatched++;
            $display("FAIL clip_sticky cyc %0d: got %b required %b", cyc, clip_sticky, exp_s);
        end
    end

    function automatic int lane(input int q, input int c, input int k);
        logic signed [DW-1:0] s;
        s = dacout[((q*2+c)*TS+k)*DW +: DW];
        return int'(s);
    endfunction

    function automatic int cnt(input int q);
        return int'(clip_count[q*CW +: CW]);
    endfunction

    task automatic pin(input string nm, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        xin = '0; yin = '0; qsel = '0; in_valid = 0; daczero = 0;
        gstrobe = 0; clip_clear = 0; gaddr = '0; gdata = '0;
    endtask

    task automatic set_slice(input int j, input int k, input int xv, input int yv);
        xin[(j*TS+k)*DW +: DW] = DW'(xv);
        yin[(j*TS+k)*DW +: DW] = DW'(yv);
    endtask

    task automatic set_elem(input int j, input int xv, input int yv);
        for (int k = 0; k < TS; k++) set_slice(j, k, xv, yv);
    endtask

    task automatic sat_stream(input int xv);
        for (int j = 0; j < NEL; j++) begin
            set_elem(j, xv, 0);
            qsel[j*QB+1] = 1'b1;
        end
        in_valid = 1;
    endtask

    initial begin
        int first, prev, trans, mixed, v;
        rst_n = 0;
        clear_in();
        repeat (3) step();
        pin("reset_out_valid", int'(out_valid), 0);
        pin("reset_dacout", lane(0, 0, 0), 0);
        pin("reset_gain_unity_count", cnt(1), 0);
        rst_n = 1;

        // Routing: element 0 to output 0 at unity gain.
        set_elem(0, 1000, -1000);
        qsel[0] = 1'b1;
        in_valid = 1;
        step();
        clear_in();
        repeat (4) step();
        pin("route_valid_early", int'(out_valid), 0);
        step();
        pin("route_valid", int'(out_valid), 1);
        for (int k = 0; k < TS; k++) begin
            pin("route_i", lane(0, 0, k), 1000);
            pin("route_q", lane(0, 1, k), -1000);
        end
        pin("route_other", lane(1, 0, 0), 0);

        // Saturation both directions on output 1.
        repeat (2) step();
        sat_stream(8000);
        repeat (4) step();
        sat_stream(-8000);
        repeat (2) step();
        clear_in();
        pin("sat_pos", lane(1, 0, 3), 32767);
        pin("sat_q_zero", lane(1, 1, 0), 0);
        pin("sat_count1", cnt(1), 1);
        pin("sat_sticky1", int'(clip_sticky[1]), 1);
        repeat (5) step();
        pin("sat_neg", lane(1, 0, 0), -32768);
        pin("sat_count6", cnt(1), 6);

        // Rounding at half gain on output 2.
        repeat (3) step();
        gaddr = 2'd2; gdata = 16'd8192; gstrobe = 1;
        step();
        gstrobe = 0;
        set_slice(0, 0, 1001, -3);
        set_slice(0, 1, -1001, 0);
        set_slice(0, 2, 3, 0);
        qsel[2] = 1'b1;
        in_valid = 1;
        step();
        clear_in();
        repeat (5) step();
        pin("round_1001", lane(2, 0, 0), 501);
        pin("round_m1001", lane(2, 0, 1), -500);
        pin("round_3", lane(2, 0, 2), 2);
        pin("round_m3", lane(2, 1, 0), -1);

        // Gain change mid-stream on output 0.
        repeat (3) step();
        set_elem(1, 2000, 2000);
        qsel[1*QB+0] = 1'b1;
        first = -1; prev = 0; trans = 0; mixed = 0;
        for (int i = 0; i < 30; i++) begin
            in_valid = (i < 20);
            if (i == 5) begin
                gaddr = 2'd0; gdata = 16'd32767; gstrobe = 1;
            end else if (i == 8) begin
                gaddr = 2'd0; gdata = 16'd100; gstrobe = 0;
            end else gstrobe = 0;
            step();
            if (out_valid) begin
                v = lane(0, 0, 0);
                for (int c = 0; c < 2; c++)
                    for (int k = 0; k < TS; k++)
                        if (lane(0, c, k) != v) mixed++;
                if (first < 0) first = v;
                else if (v != prev) trans++;
                prev = v;
            end
        end
        clear_in();
        pin("gain_first", first, 2000);
        pin("gain_last", prev, 4000);
        pin("gain_transitions", trans, 1);
        pin("gain_mixed", mixed, 0);
        pin("gain_no_clip", int'(clip_sticky[0]), 0);

        // Mute during a saturating stream.
        repeat (3) step();
        sat_stream(8000);
        repeat (8) step();
        daczero = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) daczero = 0;
            pin("mute_zero", lane(1, 0, 0), 0);
            pin("mute_valid", int'(out_valid), 1);
            pin("mute_count", cnt(1), 9);
        end
        step();
        pin("mute_resume", lane(1, 0, 0), 32767);
        pin("mute_resume_count", cnt(1), 10);

        // Clear colliding with a clip, then counter saturation.
        repeat (2) step();
        clip_clear = 1;
        step();
        clip_clear = 0;
        pin("clear_count", cnt(1), 0);
        pin("clear_sticky", int'(clip_sticky[1]), 0);
        step();
        pin("after_clear_count", cnt(1), 1);
        pin("after_clear_sticky", int'(clip_sticky[1]), 1);
        repeat (16) step();
        pin("count_saturated", cnt(1), 15);
        clear_in();
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
